// File: rtl/cmul_conj_16_axis_pkg.sv
// Shared definitions for the 16-bit complex multiply / round paths.
// Holds sample field widths, I/Q bit positions and the round-saturate
// function used by every rounding block in this family.
package cmul_conj_16_axis_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned PROD_W   = 32;
    localparam int unsigned SUM_W    = 33;

    localparam int unsigned I_MSB = 31;
    localparam int unsigned I_LSB = 16;
    localparam int unsigned Q_MSB = 15;
    localparam int unsigned Q_LSB = 0;

    typedef struct packed {
        logic [SAMPLE_W-1:0] val;
        logic                clip;
    } rs_t;

    // Round half toward +inf (add 2^(shift-1), arithmetic shift), then clamp
    // to the signed 16-bit range. One guard bit keeps the bias add exact.
    function automatic rs_t round_sat(input logic [SUM_W-1:0] x, input int unsigned shift);
        logic signed [SUM_W:0] ext;
        logic signed [SUM_W:0] bias;
        logic signed [SUM_W:0] r;
        rs_t                   res;
        ext  = {x[SUM_W-1], x};
        bias = {{SUM_W{1'b0}}, 1'b1} << (shift - 1);
        r    = (ext + bias) >>> shift;
        if (r > 34'sd32767) begin
            res.val  = 16'h7fff;
            res.clip = 1'b1;
        end else if (r < -34'sd32768) begin
            res.val  = 16'h8000;
            res.clip = 1'b1;
        end else begin
            res.val  = r[SAMPLE_W-1:0];
            res.clip = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmul_conj_16_axis_round_sat_16.sv
// round_sat_16: combinational 33-bit -> 16-bit round/saturate with clip flag.
// Ports:
//   x    in  33  full-precision signed sum
//   y    out 16  rounded, saturated result
//   clip out 1   result was saturated
import cmul_conj_16_axis_pkg::*;

module round_sat_16 #(
    parameter int unsigned SHIFT = 15
) (
    input  logic [SUM_W-1:0]    x,
    output logic [SAMPLE_W-1:0] y,
    output logic                clip
);

    rs_t r;

    always_comb begin
        r    = round_sat(x, SHIFT);
        y    = r.val;
        clip = r.clip;
    end

endmodule

// File: rtl/cmul_conj_16_axis.sv
// cmul_conj_16_axis: AXI-stream complex mixer, o = a * conj(b) (CONJ=1) or
// o = a * b (CONJ=0), 16-bit I/Q in and out, 3-stage pipeline.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   a_tdata/a_tlast/a_tvalid/a_tready  sample a stream (I=[31:16], Q=[15:0])
//   b_tdata/b_tlast/b_tvalid/b_tready  sample b stream (b_tlast ignored)
//   o_tdata/o_tlast/o_tvalid/o_tready  result stream
//   o_clip                        I or Q of this beat saturated
import cmul_conj_16_axis_pkg::*;

module cmul_conj_16_axis #(
    parameter bit          CONJ  = 1'b1,
    parameter int unsigned SHIFT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a_tdata,
    input  logic        a_tlast,
    input  logic        a_tvalid,
    output logic        a_tready,
    input  logic [31:0] b_tdata,
    input  logic        b_tlast,
    input  logic        b_tvalid,
    output logic        b_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        o_clip
);

    logic                       en;
    logic                       take;
    logic                       v1, v2;
    logic                       l1, l2;
    logic signed [SAMPLE_W-1:0] a_i, a_q, b_i, b_q;
    logic signed [PROD_W-1:0]   p_ii, p_qq, p_qi, p_iq;
    logic [SUM_W-1:0]           s_i, s_q;
    logic [SAMPLE_W-1:0]        r_i, r_q;
    logic                       c_i, c_q;
    logic                       unused_b_tlast;

    assign unused_b_tlast = b_tlast;

    assign a_i = a_tdata[I_MSB:I_LSB];
    assign a_q = a_tdata[Q_MSB:Q_LSB];
    assign b_i = b_tdata[I_MSB:I_LSB];
    assign b_q = b_tdata[Q_MSB:Q_LSB];

    // Whole pipeline moves as one; bubbles are not collapsed.
    assign en       = o_tready | ~o_tvalid;
    assign a_tready = reset_n & en & b_tvalid;
    assign b_tready = reset_n & en & a_tvalid;
    assign take     = reset_n & en & a_tvalid & b_tvalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_clip   <= 1'b0;
        end else if (en) begin
            v1       <= take;
            v2       <= v1;
            o_tvalid <= v2;
            o_tdata  <= {r_i, r_q};
            o_tlast  <= v2 & l2;
            o_clip   <= v2 & (c_i | c_q);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            p_ii <= a_i * b_i;
            p_qq <= a_q * b_q;
            p_qi <= a_q * b_i;
            p_iq <= a_i * b_q;
            l1   <= a_tlast;
            if (CONJ) begin
                s_i <= {p_ii[PROD_W-1], p_ii} + {p_qq[PROD_W-1], p_qq};
                s_q <= {p_qi[PROD_W-1], p_qi} - {p_iq[PROD_W-1], p_iq};
            end else begin
                s_i <= {p_ii[PROD_W-1], p_ii} - {p_qq[PROD_W-1], p_qq};
                s_q <= {p_qi[PROD_W-1], p_qi} + {p_iq[PROD_W-1], p_iq};
            end
            l2   <= l1;
        end
    end

    round_sat_16 #(.SHIFT(SHIFT)) u_rs_i (.x(s_i), .y(r_i), .clip(c_i));
    round_sat_16 #(.SHIFT(SHIFT)) u_rs_q (.x(s_q), .y(r_q), .clip(c_q));

endmodule

// File: doc/cmul_conj_16_axis.md
Name: cmul_conj_16_axis

Overview:
- Streaming complex mixer for the receive direction. It computes o = a × conj(b) on 16-bit I/Q samples and rounds/saturates the result back to 16-bit I/Q. It is the counterpart of the transmit-side complex multiply/round path.
- Typical use: a = received samples, b = NCO/LO samples, o = down-converted baseband.
- Unlike the transmit path, it is fully AXI-stream handshaked on every port: input join, pipelined datapath, backpressure honoured.

Parameters:
- CONJ, 1, 1: o = a × conj(b); 0: o = a × b (plain multiply, same pipeline).
- SHIFT, 15, right-shift applied to full-precision sum before saturation; legal range 1..17.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- a_tdata  in  32  sample a, I = [31:16], Q = [15:0], signed two's complement
- a_tlast  in  1  packet boundary; propagated to output
- a_tvalid  in  1  a beat valid
- a_tready  out  1  a beat accepted
- b_tdata  in  32  sample b, same format
- b_tlast  in  1  ignored
- b_tvalid  in  1  b beat valid
- b_tready  out  1  b beat accepted
- o_tdata  out  32  result, I = [31:16], Q = [15:0]
- o_tlast  out  1  copy of a_tlast for this beat
- o_tvalid  out  1  result valid
- o_tready  in  1  downstream accept
- o_clip  out  1  high with a beat whose I or Q saturated; qualified by o_tvalid

Behaviour:
- Reset: reset_n low asynchronously clears all pipeline valid bits. Data registers need no reset.
  - o_tvalid = 0, o_tlast = 0, o_clip = 0, o_tdata = 0.
  - a_tready = b_tready = 0 while reset_n is low.
  - Mid-stream reset discards all in-flight beats; first output after release is the first beat joined after release.
- Pipeline advance: en = o_tready | ~o_tvalid. The whole 3-stage pipeline shifts when en = 1; all stages hold when en = 0. Bubbles are not collapsed.
- Join:
  - a_tready = en & b_tvalid; b_tready = en & a_tvalid.
  - A beat enters only when a_tvalid & b_tvalid & en, consuming one a and one b simultaneously.
  - A lone valid on one side is never consumed.
- Latency: 3 cycles from accepted input beat to o_tvalid with no stall. Throughput is 1 beat/cycle while o_tready = 1.
- Stage 1: four signed 16x16 → 32-bit products: aI·bI, aQ·bQ, aQ·bI, aI·bQ.
- Stage 2: 33-bit signed sums.
  - CONJ=1: I = aI·bI + aQ·bQ; Q = aQ·bI − aI·bQ.
  - CONJ=0: I = aI·bI − aQ·bQ; Q = aQ·bI + aI·bQ.
- Stage 3, round then saturate:
  - Round: add 2^(SHIFT−1), then arithmetic shift right by SHIFT. Ties round toward +inf.
  - Saturate: clamp to [−32768, 32767].
  - o_clip = saturation of I or Q.
- tlast, valid and clip travel in lockstep with data. Output holds stable while o_tvalid & ~o_tready (AXI-stream rule).

Decomposition:
- Shared package: sample field widths (16/32/33), I/Q bit positions, and the round-saturate function. The same function is reused by other rounding blocks.
- One natural sub-module: round_sat_16, a combinational 33-bit → 16-bit round/saturate with clip flag, instantiated for I and Q.

Test Plan:
- a=(16384,0), b=(0,16384), CONJ=1, SHIFT=15 → o=(0,−8192), o_clip=0; o_tvalid exactly 3 cycles after join.
- a=(−32768,−32768), b=(−32768,32767) → full-precision I = 32768, Q = 2^31−32768; output o=(1,32767), o_clip=1.
- Rounding ties, b=(16384,0), SHIFT=15:
  - a=(1,0) → I=1 (+0.5 rounds up).
  - a=(−1,0) → I=0 (−0.5 rounds toward +inf).
- Join: a_tvalid=1 for 5 cycles with b_tvalid=0 → no ready, no output. Then b_tvalid=1 → one beat per cycle, with a_tready = b_tready.
- Backpressure: stream 8 beats with incrementing aI and a_tlast on beat 8; toggle o_tready pseudo-randomly → 8 outputs in order, no drop or duplicate, data stable while stalled, o_tlast only on beat 8.
- Reset: pulse reset_n low with 3 beats in flight → o_tvalid drops immediately; after release only new beats appear.
